// File: rtl/conv_pkg.sv
// Shared conv-pipeline constants, types and the requantisation helper.
// Used by the conv stage and by relu_maxpool.
package conv_pkg;

  localparam int IMG_WIDTH_DEF  = 28;
  localparam int IMG_HEIGHT_DEF = 28;
  localparam int CHANNEL_DEF    = 8;
  localparam int ACC_W          = 32;
  localparam int ACT_W          = 8;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [ACT_W-1:0] act_t;

  localparam act_t ACT_MAX = act_t'(127);

  function automatic act_t act_max(input act_t a, input act_t b);
    return (a > b) ? a : b;
  endfunction

  // ReLU, arithmetic shift, clamp to 0..127.
  function automatic act_t requant(input acc_t v, input int unsigned shift);
    acc_t s;
    if (v[ACC_W-1]) return '0;
    s = v >>> shift;
    if (s > acc_t'(127)) return ACT_MAX;
    return s[ACT_W-1:0];
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one horizontally pooled row: one write port,
// one combinational read port, no reset on the storage.
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF / 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  act_t          wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output act_t          rd_data_o
);

  act_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU + requantisation followed by 2x2 stride-2 max pooling over a
// raster-ordered stream (x fastest, then y, then channel).
module relu_maxpool
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int CHANNEL    = CHANNEL_DEF,
  parameter int SHIFT      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  output logic [ACT_W-1:0] out_data,
  output logic             frame_done
);

  localparam int XW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW       = (CHANNEL    > 1) ? $clog2(CHANNEL)    : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] ch_q, ch_d;
  act_t          hold_q, hold_d;
  act_t          out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  act_t             q;
  act_t             lb_rd;
  logic             lb_we;
  logic [LB_AW-1:0] lb_addr;
  logic             x_last, y_last, ch_last;

  assign q       = requant($signed(in_data), SHIFT);
  assign lb_addr = LB_AW'(x_q >> 1);
  assign x_last  = (x_q  == XW'(IMG_WIDTH - 1));
  assign y_last  = (y_q  == YW'(IMG_HEIGHT - 1));
  assign ch_last = (ch_q == CW'(CHANNEL - 1));

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (lb_we),
    .wr_addr_i (lb_addr),
    .wr_data_i (act_max(hold_q, q)),
    .rd_addr_i (lb_addr),
    .rd_data_o (lb_rd)
  );

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    ch_d         = ch_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;

    if (in_valid) begin
      if (x_last) begin
        x_d = '0;
        if (y_last) begin
          y_d  = '0;
          ch_d = ch_last ? '0 : ch_q + 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end

      // Even rows fill every linebuf entry before the odd row reads it,
      // so stale contents from an earlier channel never leak through.
      case ({y_q[0], x_q[0]})
        2'b00: hold_d = q;
        2'b01: lb_we  = 1'b1;
        2'b10: hold_d = act_max(lb_rd, q);
        default: begin
          out_data_d   = act_max(hold_q, q);
          out_valid_d  = 1'b1;
          frame_done_d = x_last && y_last && ch_last;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      ch_q         <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      ch_q         <= ch_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: two instances (SHIFT=0 and SHIFT=8) share one
// stimulus stream and are checked against a frame-array reference model.
module tb_relu_maxpool;

  localparam int W = 4;
  localparam int H = 4;
  localparam int C = 2;
  localparam int N = W * H * C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        ov0, fd0, ov8, fd8;
  logic [7:0]  od0, od8;

  always #5 clk = ~clk;

  relu_maxpool #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CHANNEL(C), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_data(od0), .frame_done(fd0));

  relu_maxpool #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CHANNEL(C), .SHIFT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov8), .out_data(od8), .frame_done(fd8));

  int n_vec = 0;
  int n_err = 0;
  int idx;
  int img [N];
  int exp0, exp8;
  int fd_cnt;
  int got0_q[$];
  int got8_q[$];
  int fr [N];
  int ramp_exp [8] = '{5, 7, 13, 15, 21, 23, 29, 31};

  function automatic int rq(int v, int sh);
    int s;
    if (v < 0) return 0;
    s = v >>> sh;
    return (s > 127) ? 127 : s;
  endfunction

  function automatic int pool(int c, int py, int px, int sh);
    int m = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        int v = rq(img[c*W*H + (2*py+dy)*W + 2*px + dx], sh);
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(bit v, int d);
    bit ev = 1'b0;
    bit ef = 1'b0;
    int x, y, c;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    if (v) begin
      img[idx] = d;
      x = idx % W;
      y = (idx / W) % H;
      c = idx / (W * H);
      if ((x % 2 == 1) && (y % 2 == 1)) begin
        ev   = 1'b1;
        ef   = (idx == N - 1);
        exp0 = pool(c, y / 2, x / 2, 0);
        exp8 = pool(c, y / 2, x / 2, 8);
      end
      idx = (idx + 1) % N;
    end
    chk("out_valid_s0",  ov0, ev);
    chk("frame_done_s0", fd0, ef);
    chk("out_data_s0",   od0, exp0);
    chk("out_valid_s8",  ov8, ev);
    chk("frame_done_s8", fd8, ef);
    chk("out_data_s8",   od8, exp8);
    if (ov0) got0_q.push_back(int'(od0));
    if (ov8) got8_q.push_back(int'(od8));
    if (fd0) fd_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid_s0",  ov0, 0);
    chk("rst_out_data_s0",   od0, 0);
    chk("rst_frame_done_s0", fd0, 0);
    chk("rst_out_valid_s8",  ov8, 0);
    chk("rst_out_data_s8",   od8, 0);
    chk("rst_frame_done_s8", fd8, 0);
    idx  = 0;
    exp0 = 0;
    exp8 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    idx      = 0;
    exp0     = 0;
    exp8     = 0;
    fd_cnt   = 0;
    do_reset();

    // Constant frame, back-to-back.
    for (int i = 0; i < N; i++) step(1'b1, 5);

    // Same frame, samples 12 cycles apart.
    for (int i = 0; i < N; i++) begin
      step(1'b1, 5);
      repeat (11) step(1'b0, 0);
    end

    // Directed windows: mixed signs, all negative, saturation, SHIFT=8 case.
    for (int i = 0; i < N; i++) fr[i] = int'($urandom_range(0, 4000)) - 2000;
    fr[0] = 3;  fr[1] = 9;    fr[4] = -4; fr[5] = 7;
    fr[2] = -1; fr[3] = -100; fr[6] = -7; fr[7] = -2;
    fr[10] = 1000;
    fr[16] = 32'h1234; fr[17] = 0; fr[20] = 0; fr[21] = 0;
    got0_q.delete();
    got8_q.delete();
    for (int i = 0; i < N; i++) step(1'b1, fr[i]);
    chk("dir_mixed_window", got0_q[0], 9);
    chk("dir_negative_window", got0_q[1], 0);
    chk("dir_saturate", got0_q[3], 127);
    chk("dir_shift8", got8_q[4], 18);

    // Two random frames, no gap.
    fd_cnt = 0;
    for (int i = 0; i < 2 * N; i++) step(1'b1, int'($urandom_range(0, 70000)) - 20000);
    chk("frame_done_count", fd_cnt, 2);

    // Abort mid-frame, then a clean ramp frame.
    for (int i = 0; i < 6; i++) step(1'b1, 99);
    do_reset();
    got0_q.delete();
    for (int i = 0; i < N; i++) step(1'b1, i);
    chk("ramp_count", got0_q.size(), 8);
    for (int i = 0; i < 8 && i < got0_q.size(); i++) chk("ramp_value", got0_q[i], ramp_exp[i]);

    // Random frame with random idle gaps.
    for (int i = 0; i < N; i++) begin
      step(1'b1, int'($urandom_range(0, 70000)) - 20000);
      repeat ($urandom_range(0, 3)) step(1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
